// File: rtl/rv32i_regfile_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_regfile_arbiter
//  Purpose  : Shares a 2R/1W register file between the core and a debug port,
//             zero-fills x1..x31 after reset and never writes x0.
//  Revision : 1.0
// ============================================================================
module rv32i_regfile_arbiter #(
    parameter int CLEAR_ON_RESET = 1,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        core_we_i,
    input  logic [4:0]  core_rs1_i,
    input  logic [4:0]  core_rs2_i,
    input  logic [4:0]  core_rd_i,
    input  logic [31:0] core_din_i,
    output logic [31:0] core_rsa_o,
    output logic [31:0] core_rsb_o,
    output logic        core_stall_o,

    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [4:0]  dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic        dbg_ack_o,
    output logic [31:0] dbg_rdata_o,

    output logic        rf_we_o,
    output logic [4:0]  rf_rs1_o,
    output logic [4:0]  rf_rs2_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_din_o,
    input  logic [31:0] rf_rsa_i,
    input  logic [31:0] rf_rsb_i
);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        DBG   = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
    localparam logic       CLR_EN     = (CLEAR_ON_RESET != 0);

    state_t      state_q;
    logic [4:0]  clr_cnt_q;
    logic [7:0]  wait_cnt_q;
    logic        stall_q;
    logic        ack_q;
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= CLR_EN ? CLEAR : RUN;
            clr_cnt_q  <= 5'd1;
            wait_cnt_q <= 8'd0;
            stall_q    <= CLR_EN;
            ack_q      <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clr_cnt_q == 5'd31) begin
                        state_q <= RUN;
                        stall_q <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 5'd1;
                    end
                end
                RUN: begin
                    // A pending request waits only on core writes, and only up to STARVE_MAX cycles.
                    if (dbg_req_i && (!core_we_i || wait_cnt_q == STARVE_MAX)) begin
                        state_q    <= DBG;
                        stall_q    <= 1'b1;
                        wait_cnt_q <= 8'd0;
                    end else if (dbg_req_i) begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end else begin
                        wait_cnt_q <= 8'd0;
                    end
                end
                DBG: begin
                    state_q <= ACK;
                    ack_q   <= 1'b1;
                    if (!dbg_we_i) begin
                        rdata_q <= rf_rsa_i;
                    end
                end
                default: begin
                    state_q <= RUN;
                    ack_q   <= 1'b0;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rf_we_o  = 1'b0;
        rf_rs1_o = core_rs1_i;
        rf_rs2_o = core_rs2_i;
        rf_rd_o  = core_rd_i;
        rf_din_o = core_din_i;
        case (state_q)
            CLEAR: begin
                rf_we_o  = 1'b1;
                rf_rd_o  = clr_cnt_q;
                rf_din_o = 32'd0;
            end
            RUN: begin
                rf_we_o = core_we_i && (core_rd_i != 5'd0);
            end
            DBG: begin
                rf_we_o  = dbg_we_i && (dbg_addr_i != 5'd0);
                rf_rs1_o = dbg_addr_i;
                rf_rd_o  = dbg_addr_i;
                rf_din_o = dbg_wdata_i;
            end
            default: begin
                rf_we_o = 1'b0;
            end
        endcase
    end

    assign core_rsa_o   = rf_rsa_i;
    assign core_rsb_o   = rf_rsb_i;
    assign core_stall_o = stall_q;
    assign dbg_ack_o    = ack_q;
    assign dbg_rdata_o  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_regfile_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32i_regfile_arbiter
//  Purpose  : Directed vectors and corner sequences against a behavioural RF.
//  Revision : 1.0
// ============================================================================
module tb_rv32i_regfile_arbiter;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        core_we_i = 1'b0;
    logic [4:0]  core_rs1_i = 5'd0;
    logic [4:0]  core_rs2_i = 5'd0;
    logic [4:0]  core_rd_i = 5'd0;
    logic [31:0] core_din_i = 32'd0;
    logic [31:0] core_rsa_o, core_rsb_o;
    logic        core_stall_o;
    logic        dbg_req_i = 1'b0;
    logic        dbg_we_i = 1'b0;
    logic [4:0]  dbg_addr_i = 5'd0;
    logic [31:0] dbg_wdata_i = 32'd0;
    logic        dbg_ack_o;
    logic [31:0] dbg_rdata_o;
    logic        rf_we_o;
    logic [4:0]  rf_rs1_o, rf_rs2_o, rf_rd_o;
    logic [31:0] rf_din_o;
    logic [31:0] rf_rsa_i, rf_rsb_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv32i_regfile_arbiter #(.CLEAR_ON_RESET(1), .STARVE_LIMIT(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .core_we_i(core_we_i), .core_rs1_i(core_rs1_i), .core_rs2_i(core_rs2_i),
        .core_rd_i(core_rd_i), .core_din_i(core_din_i),
        .core_rsa_o(core_rsa_o), .core_rsb_o(core_rsb_o), .core_stall_o(core_stall_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o),
        .rf_we_o(rf_we_o), .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o),
        .rf_rd_o(rf_rd_o), .rf_din_o(rf_din_o),
        .rf_rsa_i(rf_rsa_i), .rf_rsb_i(rf_rsb_i)
    );

    // Behavioural register file; reset fills x1..x31 with garbage so the zero-fill is observable.
    logic [31:0] regs [32];
    always @(posedge clk) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'd0 : (32'hA5A5_0000 | i);
        end else if (rf_we_o) begin
            regs[rf_rd_o] <= rf_din_o;
        end
    end
    assign rf_rsa_i = regs[rf_rs1_o];
    assign rf_rsb_i = regs[rf_rs2_o];

    typedef struct {
        logic        we;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] din;
        logic        exp_we;
        logic [31:0] exp_rsa;
        logic [31:0] exp_rsb;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic core_idle();
        core_we_i = 1'b0; core_rs1_i = 5'd0; core_rs2_i = 5'd0;
        core_rd_i = 5'd0; core_din_i = 32'd0;
    endtask

    task automatic run_clear(input string tag);
        logic ok;
        ok = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            if (!(rf_we_o === 1'b1 && rf_rd_o === 5'(i) && rf_din_o === 32'd0 && core_stall_o === 1'b1))
                ok = 1'b0;
            step();
        end
        chk({tag, "_sequence"}, {31'd0, ok}, 32'd1);
        chk({tag, "_stall_drop"}, {31'd0, core_stall_o}, 32'd0);
        chk({tag, "_we_after"}, {31'd0, rf_we_o}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd0, 5'd0, 5'd3, 32'hDEADBEEF, 1'b1, 32'h0, 32'h0};
        vecs[1] = '{1'b1, 5'd3, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b0, 5'd3, 5'd0, 5'd0, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[3] = '{1'b1, 5'd5, 5'd3, 5'd5, 32'h0000_0055, 1'b1, 32'h0, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 5'd5, 5'd3, 5'd9, 32'h1111_1111, 1'b0, 32'h55, 32'hDEADBEEF};
        vecs[5] = '{1'b0, 5'd0, 5'd31, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0};

        // Reset state and zero-fill
        repeat (3) step();
        chk("rst_stall", {31'd0, core_stall_o}, 32'd1);
        chk("rst_ack", {31'd0, dbg_ack_o}, 32'd0);
        chk("rst_rdata", dbg_rdata_o, 32'd0);
        rst_i = 1'b0;
        run_clear("clear");
        core_rs1_i = 5'd5;
        #1;
        chk("x5_after_clear", core_rsa_o, 32'd0);

        // Table-driven core traffic in RUN
        for (int i = 0; i < 6; i++) begin
            core_we_i  = vecs[i].we;  core_rs1_i = vecs[i].rs1; core_rs2_i = vecs[i].rs2;
            core_rd_i  = vecs[i].rd;  core_din_i = vecs[i].din;
            #1;
            chk($sformatf("vec%0d_we", i), {31'd0, rf_we_o}, {31'd0, vecs[i].exp_we});
            chk($sformatf("vec%0d_rsa", i), core_rsa_o, vecs[i].exp_rsa);
            chk($sformatf("vec%0d_rsb", i), core_rsb_o, vecs[i].exp_rsb);
            step();
        end
        core_idle();

        // Debug read of x3 with an idle core
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd3;
        #1;
        chk("rd_run_stall", {31'd0, core_stall_o}, 32'd0);
        step();
        chk("rd_dbg_stall", {31'd0, core_stall_o}, 32'd1);
        chk("rd_dbg_rs1", {27'd0, rf_rs1_o}, 32'd3);
        chk("rd_dbg_we", {31'd0, rf_we_o}, 32'd0);
        chk("rd_dbg_noack", {31'd0, dbg_ack_o}, 32'd0);
        step();
        chk("rd_ack", {31'd0, dbg_ack_o}, 32'd1);
        chk("rd_data", dbg_rdata_o, 32'hDEADBEEF);
        dbg_req_i = 1'b0;
        step();
        chk("rd_ack_pulse", {31'd0, dbg_ack_o}, 32'd0);
        chk("rd_stall_off", {31'd0, core_stall_o}, 32'd0);

        // Starvation: core writes x9 every cycle, debug writes x7
        begin
            int  cnt;
            logic ok;
            core_we_i = 1'b1; core_rd_i = 5'd9; core_din_i = 32'h99;
            dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd7; dbg_wdata_i = 32'h12345678;
            cnt = 0; ok = 1'b1;
            #1;
            while (!core_stall_o && cnt < 20) begin
                if (!(rf_we_o === 1'b1 && rf_rd_o === 5'd9)) ok = 1'b0;
                step();
                cnt++;
            end
            chk("starve_cycles", cnt, 32'd9);
            chk("starve_core_writes", {31'd0, ok}, 32'd1);
            chk("starve_dbg_we", {31'd0, rf_we_o}, 32'd1);
            chk("starve_dbg_rd", {27'd0, rf_rd_o}, 32'd7);
            chk("starve_dbg_din", rf_din_o, 32'h12345678);
            step();
            chk("starve_ack", {31'd0, dbg_ack_o}, 32'd1);
            chk("starve_ack_we", {31'd0, rf_we_o}, 32'd0);
            dbg_req_i = 1'b0;
            step();
            core_idle();
            core_rs1_i = 5'd7; core_rs2_i = 5'd9;
            #1;
            chk("x7_readback", core_rsa_o, 32'h12345678);
            chk("x9_readback", core_rsb_o, 32'h99);
        end

        // Debug write to x0 is suppressed
        core_idle();
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd0; dbg_wdata_i = 32'hFFFFFFFF;
        step();
        chk("x0_dbg_we", {31'd0, rf_we_o}, 32'd0);
        step();
        chk("x0_dbg_ack", {31'd0, dbg_ack_o}, 32'd1);
        chk("x0_rdata_kept", dbg_rdata_o, 32'hDEADBEEF);
        dbg_req_i = 1'b0;
        step();
        #1;
        chk("x0_reads_zero", core_rsa_o, 32'd0);

        // Reset while in DBG drops the access
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd3;
        step();
        chk("rstdbg_in_dbg", {31'd0, core_stall_o}, 32'd1);
        rst_i = 1'b1;
        step();
        chk("rstdbg_noack", {31'd0, dbg_ack_o}, 32'd0);
        chk("rstdbg_rdata", dbg_rdata_o, 32'd0);
        rst_i = 1'b0;
        dbg_req_i = 1'b0;
        chk("rstdbg_clear_rd", {27'd0, rf_rd_o}, 32'd1);
        run_clear("reclear");

        // Back-to-back: write x4 then read x4
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd4; dbg_wdata_i = 32'h44;
        step();
        chk("b2b_dbg1", {31'd0, core_stall_o}, 32'd1);
        step();
        chk("b2b_ack1", {31'd0, dbg_ack_o}, 32'd1);
        dbg_we_i = 1'b0;
        step();
        chk("b2b_run_stall", {31'd0, core_stall_o}, 32'd0);
        chk("b2b_run_noack", {31'd0, dbg_ack_o}, 32'd0);
        step();
        chk("b2b_dbg2", {31'd0, core_stall_o}, 32'd1);
        step();
        chk("b2b_ack2", {31'd0, dbg_ack_o}, 32'd1);
        chk("b2b_rdata", dbg_rdata_o, 32'h44);
        dbg_req_i = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32i_regfile_arbiter.md
Name: rv32i_regfile_arbiter

Overview:
Owns the 32x32 register file ports and shares them between the core datapath and a debug/loader requester. After reset it walks x1..x31 writing zero. It then grants the core by default and inserts single-cycle debug accesses with a req/ack handshake. Writes to x0 are suppressed from every source. It sits between the core decode/writeback stage and the register file (2 read ports, 1 write port, combinational read).

Parameters:
CLEAR_ON_RESET, 1, 1 = run the zero-fill sequence after reset; 0 = enter RUN directly.
STARVE_LIMIT, 8, number of consecutive cycles a pending debug request may be deferred by core writes before it is forced; range 1..255.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
core_we_i  in  1  core write enable
core_rs1_i  in  5  core read address A
core_rs2_i  in  5  core read address B
core_rd_i  in  5  core write address
core_din_i  in  32  core write data
core_rsa_o  out  32  read data A to core (rf_rsa_i pass-through)
core_rsb_o  out  32  read data B to core (rf_rsb_i pass-through)
core_stall_o  out  1  registered; core must hold all core_* inputs while high
dbg_req_i  in  1  debug request, held high until dbg_ack_o
dbg_we_i  in  1  debug write (1) / read (0)
dbg_addr_i  in  5  debug register index
dbg_wdata_i  in  32  debug write data
dbg_ack_o  out  1  one-cycle completion pulse
dbg_rdata_o  out  32  registered read data, valid with dbg_ack_o, held until next ack
rf_we_o  out  1  register file write enable
rf_rs1_o  out  5  register file read address A
rf_rs2_o  out  5  register file read address B
rf_rd_o  out  5  register file write address
rf_din_o  out  32  register file write data
rf_rsa_i  in  32  register file read data A
rf_rsb_i  in  32  register file read data B

Behaviour:
- States: CLEAR, RUN, DBG, ACK. 5-bit clr_cnt, 8-bit wait_cnt.
- Reset (any state, mid-sequence included): state = CLEAR with clr_cnt = 1 if CLEAR_ON_RESET, else RUN. core_stall_o = CLEAR_ON_RESET. dbg_ack_o = 0, dbg_rdata_o = 0, wait_cnt = 0. An in-flight debug access is dropped with no ack; the requester must re-request.
- CLEAR: rf_we_o = 1, rf_rd_o = clr_cnt, rf_din_o = 0, one register per cycle. clr_cnt increments 1..31. After writing x31 (31 cycles total) go to RUN. core_stall_o = 1 throughout and drops in the first RUN cycle. dbg_req_i is ignored until RUN.
- RUN: rf_rs1_o/rf_rs2_o/rf_rd_o/rf_din_o = core_*. rf_we_o = core_we_i & (core_rd_i != 0).
  - If dbg_req_i and (!core_we_i or wait_cnt == STARVE_LIMIT): next state = DBG, core_stall_o = 1 from the next cycle. The core access in this transition cycle still completes.
  - Else if dbg_req_i: wait_cnt increments.
  - wait_cnt clears on leaving RUN or when dbg_req_i is low.
- DBG (1 cycle):
  - rf_rs1_o = dbg_addr_i, rf_rd_o = dbg_addr_i, rf_din_o = dbg_wdata_i, rf_rs2_o = core_rs2_i.
  - rf_we_o = dbg_we_i & (dbg_addr_i != 0). The core write is blocked.
  - dbg_rdata_o <= rf_rsa_i (pre-write value) on reads; it is unchanged on writes.
  - Next state = ACK.
- ACK (1 cycle): dbg_ack_o = 1, core_stall_o = 1, rf_we_o = 0, then RUN unconditionally. The core regains at least one RUN cycle between debug accesses.
- Debug latency: 3 cycles from req to ack when the core is idle, 3 + STARVE_LIMIT worst case.
- x0: never written by any source. A debug read of x0 returns whatever rf_rsa_i presents (0 after CLEAR).
- core_rsa_o/core_rsb_o are always combinational pass-through. Values seen while core_stall_o = 1 are don't-care.

Test Plan:
- Reset release, CLEAR_ON_RESET = 1 -> rf_we_o high for exactly 31 cycles with rf_rd_o = 1..31 and rf_din_o = 0; core_stall_o falls in cycle 32; a core read of x5 returns 0.
- RUN, core writes x3 = 0xDEADBEEF, then dbg read x3 with the core idle -> DBG one cycle after req, dbg_ack_o pulse one cycle later, dbg_rdata_o = 0xDEADBEEF.
- core_we_i held high continuously, dbg write x7 = 0x12345678, STARVE_LIMIT = 8 -> grant after 8 deferred cycles; core write in the transition cycle commits; x7 reads 0x12345678 afterwards.
- Core write rd = 0 with data 0xFFFFFFFF, and dbg write addr 0 -> rf_we_o stays 0 in both; x0 reads 0.
- rst_i asserted in DBG -> no dbg_ack_o, CLEAR restarts at rd = 1, dbg_rdata_o = 0.
- Back-to-back debug requests (req re-raised the cycle after ack) -> pattern DBG, ACK, RUN, DBG; core_stall_o low for exactly one cycle between accesses.
